// File: rtl/cosim_log_collector.sv
// cosim_log_collector
//   Commit-log buffer on the RTL side of the cosim harness. Each hart owns
//   three FIFOs (0 = REG_WRITE, 1 = MEM_READ, 2 = MEM_WRITE). Queue index is
//   q = hart*3 + kind. All queues drain through one round-robin arbitrated,
//   tagged valid/ready stream toward the Spike comparison stage.
//
//   Optional feature macro: COSIM_LOG_TIMESTAMP_EN
//     When defined, a 64-bit free-running cycle counter timestamps every
//     accepted push. The granted item's timestamp appears on out_time_o.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_valid_i   per-queue push strobe (NQ)
//   push_item_i    per-queue item, queue q in slice q (NQ*ITEM_W)
//   push_ready_o   queue q accepts this cycle (NQ)
//   flush_i        clear all three queues of a hart (NUM_HARTS)
//   out_valid_o    head item available
//   out_ready_i    consumer accepts
//   out_item_o     granted head item
//   out_hart_o     source hart of the granted item
//   out_kind_o     source kind of the granted item
//   overflow_o     sticky per-queue drop flag
//   level_o        per-queue occupancy (NQ*LW)
//   out_time_o     granted item's timestamp (timestamp build only)
module cosim_log_collector #(
  parameter int NUM_HARTS  = 2,
  parameter int DEPTH      = 8,
  parameter int WORD_W     = 64,
  parameter int ITEM_WORDS = 3,
  localparam int NQ     = NUM_HARTS * 3,
  localparam int ITEM_W = ITEM_WORDS * WORD_W,
  localparam int HW     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NQ-1:0]        push_valid_i,
  input  logic [NQ*ITEM_W-1:0] push_item_i,
  output logic [NQ-1:0]        push_ready_o,
  input  logic [NUM_HARTS-1:0] flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ITEM_W-1:0]    out_item_o,
  output logic [HW-1:0]        out_hart_o,
  output logic [1:0]           out_kind_o,
  output logic [NQ-1:0]        overflow_o,
  output logic [NQ*LW-1:0]     level_o
`ifdef COSIM_LOG_TIMESTAMP_EN
  ,
  output logic [63:0]          out_time_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int QW = $clog2(NQ);
  localparam int MW = $clog2(NQ * DEPTH);

  // Storage is one flat array; queue q owns entries q*DEPTH .. q*DEPTH+DEPTH-1.
  logic [ITEM_W-1:0] mem_r [NQ*DEPTH];
  logic [PW-1:0]     wr_ptr_r [NQ];
  logic [PW-1:0]     rd_ptr_r [NQ];
  logic [LW-1:0]     count_r [NQ];
  logic [NQ-1:0]     overflow_r;
  logic [QW-1:0]     rr_r;
  logic [QW-1:0]     lock_grant_r;
  logic              lock_r;

  logic [NQ-1:0]     nonempty_s;
  logic [NQ-1:0]     flush_q_s;
  logic [NQ-1:0]     ready_s;
  logic [NQ-1:0]     push_acc_s;
  logic [NQ-1:0]     pop_s;
  logic              any_s;
  logic              handshake_s;
  logic [QW-1:0]     search_grant_s;
  logic [QW-1:0]     grant_s;
  logic [MW-1:0]     rd_idx_s;

`ifdef COSIM_LOG_TIMESTAMP_EN
  logic [63:0]       time_r;
  logic [63:0]       tmem_r [NQ*DEPTH];
`endif

  // Per-queue status, flush fan-out, acceptance and pop decode.
  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      nonempty_s[q] = (count_r[q] != {LW{1'b0}});
      flush_q_s[q]  = flush_i[q / 3];
      pop_s[q]      = handshake_s & (grant_s == QW'(q));
      // A pop or flush this cycle frees a slot, so a full queue may still accept.
      ready_s[q]    = (count_r[q] < LW'(DEPTH)) | pop_s[q] | flush_q_s[q];
      // Flush wins over a concurrent push: the item is discarded silently.
      push_acc_s[q] = push_valid_i[q] & ready_s[q] & ~flush_q_s[q];
    end
  end

  // Round-robin search: first non-empty queue at or above rr_r, wrapping at NQ.
  always_comb begin
    logic found;
    int   idx;
    found          = 1'b0;
    idx            = 0;
    search_grant_s = {QW{1'b0}};
    for (int i = 0; i < NQ; i++) begin
      idx = (int'(rr_r) + i >= NQ) ? int'(rr_r) + i - NQ : int'(rr_r) + i;
      if (!found && nonempty_s[QW'(idx)]) begin
        found          = 1'b1;
        search_grant_s = QW'(idx);
      end else begin
        found = found;
      end
    end
  end

  // A held grant overrides the search so the presented item cannot change.
  always_comb begin
    any_s       = |nonempty_s;
    grant_s     = lock_r ? lock_grant_r : search_grant_s;
    handshake_s = any_s & out_ready_i;
    rd_idx_s    = MW'(int'(grant_s) * DEPTH + int'(rd_ptr_r[grant_s]));
  end

  // Output presentation; tag and data read as zero whenever nothing is valid.
  always_comb begin
    push_ready_o = ready_s;
    overflow_o   = overflow_r;
    for (int q = 0; q < NQ; q++) begin
      level_o[q*LW +: LW] = count_r[q];
    end
    out_valid_o = any_s;
    if (any_s) begin
      out_item_o = mem_r[rd_idx_s];
      out_hart_o = HW'(int'(grant_s) / 3);
      out_kind_o = 2'(int'(grant_s) % 3);
    end else begin
      out_item_o = {ITEM_W{1'b0}};
      out_hart_o = {HW{1'b0}};
      out_kind_o = 2'd0;
    end
`ifdef COSIM_LOG_TIMESTAMP_EN
    out_time_o = any_s ? tmem_r[rd_idx_s] : 64'd0;
`endif
  end

  // Queue pointers, occupancy and sticky overflow flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int q = 0; q < NQ; q++) begin
        wr_ptr_r[q] <= {PW{1'b0}};
        rd_ptr_r[q] <= {PW{1'b0}};
        count_r[q]  <= {LW{1'b0}};
      end
      overflow_r <= {NQ{1'b0}};
    end else begin
      for (int q = 0; q < NQ; q++) begin
        if (flush_q_s[q]) begin
          wr_ptr_r[q]   <= {PW{1'b0}};
          rd_ptr_r[q]   <= {PW{1'b0}};
          count_r[q]    <= {LW{1'b0}};
          overflow_r[q] <= 1'b0;
        end else begin
          if (push_acc_s[q]) begin
            wr_ptr_r[q] <= wr_ptr_r[q] + PW'(1);
          end else begin
            wr_ptr_r[q] <= wr_ptr_r[q];
          end
          if (pop_s[q]) begin
            rd_ptr_r[q] <= rd_ptr_r[q] + PW'(1);
          end else begin
            rd_ptr_r[q] <= rd_ptr_r[q];
          end
          case ({push_acc_s[q], pop_s[q]})
            2'b10:   count_r[q] <= count_r[q] + LW'(1);
            2'b01:   count_r[q] <= count_r[q] - LW'(1);
            default: count_r[q] <= count_r[q];
          endcase
          if (push_valid_i[q] && !ready_s[q]) begin
            overflow_r[q] <= 1'b1;
          end else begin
            overflow_r[q] <= overflow_r[q];
          end
        end
      end
    end
  end

  // Item storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    for (int q = 0; q < NQ; q++) begin
      if (push_acc_s[q]) begin
        mem_r[MW'(q * DEPTH + int'(wr_ptr_r[q]))] <= push_item_i[q*ITEM_W +: ITEM_W];
      end
    end
  end

  // Arbiter state: hold the grant while stalled, advance the pointer on handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_r         <= {QW{1'b0}};
      lock_r       <= 1'b0;
      lock_grant_r <= {QW{1'b0}};
    end else begin
      if (handshake_s) begin
        rr_r         <= (grant_s == QW'(NQ - 1)) ? {QW{1'b0}} : grant_s + QW'(1);
        lock_r       <= 1'b0;
        lock_grant_r <= lock_grant_r;
      end else if (any_s && !flush_q_s[grant_s]) begin
        rr_r         <= rr_r;
        lock_r       <= 1'b1;
        lock_grant_r <= grant_s;
      end else begin
        // Nothing valid, or the held queue's hart is being flushed: release.
        rr_r         <= rr_r;
        lock_r       <= 1'b0;
        lock_grant_r <= lock_grant_r;
      end
    end
  end

`ifdef COSIM_LOG_TIMESTAMP_EN
  // Free-running cycle counter, wraps naturally at 2^64.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      time_r <= 64'd0;
    end else begin
      time_r <= time_r + 64'd1;
    end
  end

  // Timestamp storage written alongside the item with the accept-cycle count.
  always_ff @(posedge clk_i) begin
    for (int q = 0; q < NQ; q++) begin
      if (push_acc_s[q]) begin
        tmem_r[MW'(q * DEPTH + int'(wr_ptr_r[q]))] <= time_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cosim_log_collector.sv
// Self-checking bench for cosim_log_collector: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_cosim_log_collector;

  localparam int NH     = 2;
  localparam int DEPTH  = 8;
  localparam int NQ     = NH * 3;
  localparam int ITEM_W = 3 * 64;
  localparam int LW     = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NQ-1:0]        push_valid;
  logic [NQ*ITEM_W-1:0] push_item;
  logic [NQ-1:0]        push_ready;
  logic [NH-1:0]        flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [ITEM_W-1:0]    out_item;
  logic [0:0]           out_hart;
  logic [1:0]           out_kind;
  logic [NQ-1:0]        overflow;
  logic [NQ*LW-1:0]     level;
`ifdef COSIM_LOG_TIMESTAMP_EN
  logic [63:0]          out_time;
`endif

  cosim_log_collector #(.NUM_HARTS(NH), .DEPTH(DEPTH), .WORD_W(64), .ITEM_WORDS(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .push_valid_i(push_valid), .push_item_i(push_item), .push_ready_o(push_ready),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_item_o(out_item),
    .out_hart_o(out_hart), .out_kind_o(out_kind),
    .overflow_o(overflow), .level_o(level)
`ifdef COSIM_LOG_TIMESTAMP_EN
    , .out_time_o(out_time)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain queues plus the arbitration rules.
  logic [ITEM_W-1:0] mq [NQ][$];
  longint unsigned   mt [NQ][$];
  bit                mov [NQ];
  int                mrr;
  bit                mlock;
  int                mlg;
  longint unsigned   mcyc;

  function automatic int exp_grant();
    if (mlock) return mlg;
    for (int i = 0; i < NQ; i++) begin
      if (mq[(mrr + i) % NQ].size() > 0) return (mrr + i) % NQ;
    end
    return 0;
  endfunction

  function automatic logic [ITEM_W-1:0] rnd_item();
    logic [ITEM_W-1:0] r;
    for (int i = 0; i < ITEM_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_clear();
    for (int q = 0; q < NQ; q++) begin
      mq[q].delete();
      mt[q].delete();
      mov[q] = 1'b0;
    end
    mrr = 0; mlock = 1'b0; mlg = 0; mcyc = 64'd0;
  endfunction

  // Drive one cycle (called just after a negedge), check, advance the model.
  task automatic cycle(input logic [NQ-1:0] pv, input logic [NH-1:0] fl, input logic rdy);
    int g;
    bit v;
    bit hs;
    logic [NQ-1:0] erdy;
    push_valid = pv; flush = fl; out_ready = rdy;
    #1;
    g = exp_grant();
    v = 1'b0;
    for (int q = 0; q < NQ; q++) if (mq[q].size() > 0) v = 1'b1;
    hs = v && rdy;
    check_eq("out_valid", out_valid, v);
    if (v) begin
      check_eq("out_item", out_item, mq[g][0]);
      check_eq("out_hart", out_hart, g / 3);
      check_eq("out_kind", out_kind, g % 3);
`ifdef COSIM_LOG_TIMESTAMP_EN
      check_eq("out_time", out_time, mt[g][0]);
`endif
    end else begin
      check_eq("idle_item", out_item, 0);
      check_eq("idle_tag", {out_hart, out_kind}, 0);
    end
    for (int q = 0; q < NQ; q++) begin
      erdy[q] = (mq[q].size() < DEPTH) || (hs && g == q) || fl[q / 3];
      check_eq($sformatf("push_ready%0d", q), push_ready[q], erdy[q]);
      check_eq($sformatf("level%0d", q), level[q*LW +: LW], mq[q].size());
      check_eq($sformatf("overflow%0d", q), overflow[q], mov[q]);
    end
    for (int q = 0; q < NQ; q++) begin
      if (fl[q / 3]) begin
        mq[q].delete(); mt[q].delete(); mov[q] = 1'b0;
      end else begin
        if (hs && g == q) begin
          void'(mq[q].pop_front());
          void'(mt[q].pop_front());
        end
        if (pv[q]) begin
          if (erdy[q]) begin
            mq[q].push_back(push_item[q*ITEM_W +: ITEM_W]);
            mt[q].push_back(mcyc);
          end else begin
            mov[q] = 1'b1;
          end
        end
      end
    end
    if (hs) begin
      mrr = (g + 1) % NQ; mlock = 1'b0;
    end else if (v && !fl[g / 3]) begin
      mlock = 1'b1; mlg = g;
    end else begin
      mlock = 1'b0;
    end
    mcyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
  task automatic do_reset();
    #2;
    rst = 1'b1; push_valid = '0; flush = '0; out_ready = 1'b0;
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_item", out_item, 0);
    check_eq("rst_ready", push_ready, {NQ{1'b1}});
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push_valid = '0; push_item = '0; flush = '0; out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Single REG_WRITE item on hart 0 with the consumer always ready.
    push_item[0 +: ITEM_W] = 192'hA;
    cycle(6'b000001, 2'b00, 1'b1);
    cycle(6'b000000, 2'b00, 1'b1);
    cycle(6'b000000, 2'b00, 1'b1);

    // Three queues pushed together drain q0, q2, q4; then q0 vs q5 shows rr = 5.
    do_reset();
    for (int q = 0; q < NQ; q++) push_item[q*ITEM_W +: ITEM_W] = rnd_item();
    cycle(6'b010101, 2'b00, 1'b1);
    repeat (4) cycle(6'b000000, 2'b00, 1'b1);
    cycle(6'b100001, 2'b00, 1'b0);
    repeat (3) cycle(6'b000000, 2'b00, 1'b1);

    // Stall with q1 granted and q0 also filled; q1 then q0 after release.
    do_reset();
    cycle(6'b000001, 2'b00, 1'b0);
    cycle(6'b000000, 2'b00, 1'b1);
    for (int q = 0; q < NQ; q++) push_item[q*ITEM_W +: ITEM_W] = rnd_item();
    cycle(6'b000011, 2'b00, 1'b0);
    repeat (5) cycle(6'b000000, 2'b00, 1'b0);
    repeat (3) cycle(6'b000000, 2'b00, 1'b1);

    // Fill q3, overflow on the 9th push, then a 9th push alongside a pop.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_item[3*ITEM_W +: ITEM_W] = rnd_item();
      cycle(6'b001000, 2'b00, 1'b0);
    end
    check_eq("full_overflow3", overflow[3], 1'b1);
    check_eq("full_level3", level[3*LW +: LW], 4'd8);
    push_item[3*ITEM_W +: ITEM_W] = rnd_item();
    cycle(6'b001000, 2'b00, 1'b1);
    cycle(6'b000000, 2'b00, 1'b0);

    // Lock on q4 then flush hart 1 together with a discarded push to q3.
    do_reset();
    cycle(6'b001000, 2'b00, 1'b0);
    cycle(6'b000000, 2'b00, 1'b1);
    for (int q = 0; q < NQ; q++) push_item[q*ITEM_W +: ITEM_W] = rnd_item();
    cycle(6'b111000, 2'b00, 1'b0);
    repeat (2) cycle(6'b000000, 2'b00, 1'b0);
    cycle(6'b001000, 2'b10, 1'b0);
    check_eq("flush_valid", out_valid, 1'b0);
    check_eq("flush_level", level, 0);
    cycle(6'b000000, 2'b00, 1'b1);

    // Randomized traffic with occasional flushes and asynchronous resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [NQ-1:0] pv;
      logic [NH-1:0] fl;
      for (int q = 0; q < NQ; q++) begin
        push_item[q*ITEM_W +: ITEM_W] = rnd_item();
        pv[q] = ($urandom_range(99) < ((n / 500) % 2 == 0 ? 30 : 8));
      end
      for (int h = 0; h < NH; h++) fl[h] = ($urandom_range(99) < 3);
      cycle(pv, fl, ($urandom_range(99) < ((n / 250) % 2 == 0 ? 25 : 70)));
      if (n == 1700) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cosim_log_collector.md
Name: cosim_log_collector

Overview:
- Multi-hart, multi-kind commit-log buffer on the RTL side of the cosim harness.
- Captures per-hart register-write, memory-read and memory-write log items into independent FIFOs.
- Drains them as one tagged valid/ready stream toward the Spike comparison stage.
- Generalises single-hart, per-call log retrieval to NUM_HARTS channels with bounded depth, overflow tracking and per-hart flush.

Parameters:
- NUM_HARTS, 2: number of hart channels; minimum 1.
- DEPTH, 8: entries per queue; power of two, minimum 2.
- WORD_W, 64: width of one DPI word in bits.
- ITEM_WORDS, 3: DPI words per log item; shorter items are zero-padded by the producer.
- NUM_KINDS, 3 (fixed): 0 = REG_WRITE, 1 = MEM_READ, 2 = MEM_WRITE.
- Derived: NQ = NUM_HARTS*3; queue index q = hart*3 + kind.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- push_valid_i  in  NQ  per-queue push strobe.
- push_item_i  in  NQ*ITEM_WORDS*WORD_W  per-queue item; queue q occupies slice q.
- push_ready_o  out  NQ  queue q accepts this cycle.
- flush_i  in  NUM_HARTS  clear all three queues of a hart.
- out_valid_o  out  1  head item available.
- out_ready_i  in  1  consumer accepts.
- out_item_o  out  ITEM_WORDS*WORD_W  selected head item.
- out_hart_o  out  max(1,$clog2(NUM_HARTS))  source hart.
- out_kind_o  out  2  source kind.
- overflow_o  out  NQ  sticky: an item was dropped on queue q.
- level_o  out  NQ*$clog2(DEPTH+1)  per-queue occupancy.

Behaviour:
- Reset values: all queues empty; level_o = 0; overflow_o = 0; out_valid_o = 0; out_item_o/out_hart_o/out_kind_o = 0; round-robin pointer = 0; lock = 0.
- Queue = circular buffer with wr_ptr/rd_ptr of width $clog2(DEPTH) that wrap modulo DEPTH, plus a separate count.
- push_ready_o[q] = (count < DEPTH) | pop of q in this cycle | flush of q's hart in this cycle.
- Accepted push is written on the clock edge and first visible at the output the following cycle (1-cycle latency); no same-cycle bypass.
- Push with push_ready_o[q] = 0: item dropped, overflow_o[q] set, count unchanged.
- Simultaneous push and pop on one queue: count unchanged, both pointers advance; legal when full.
- Arbiter: out_valid_o = 1 when any queue is non-empty.
  - When unlocked, grant goes to the first non-empty q, searching from the RR pointer upward and wrapping at NQ.
  - If out_valid_o & ~out_ready_i, lock = 1 and the grant is held; out_item/hart/kind stay stable until handshake.
  - On handshake (valid & ready): pop the granted queue, RR pointer = grant+1 mod NQ, lock = 0.
- flush_i[h]: on the next edge, counts and pointers of queues 3h..3h+2 go to 0 and their overflow bits clear.
  - A push to a flushed queue in the same cycle is discarded (flush wins) and does not set overflow.
  - If the locked grant belongs to h, the lock drops. out_valid_o may then deassert without a handshake; this is the only permitted withdrawal.
- Pop on a queue that is flushed in the same cycle: handshake completes using the pre-flush head; the queue ends empty.
- Async reset mid-operation: all state returns to reset values immediately; in-flight items are lost.

Optional Feature:
- Macro COSIM_LOG_TIMESTAMP_EN.
- Defined:
  - 64-bit free-running cycle counter, reset to 0, wraps modulo 2^64.
  - Each accepted push stores the counter value of its accept cycle alongside the item.
  - Extra output port out_time_o (64 bits) presents the granted item's timestamp; 0 at reset.
- Undefined: no counter, no timestamp storage, no out_time_o port.

Test Plan:
- Reset, then push hart0 REG_WRITE item 0xA; out_ready_i = 1 -> one cycle later out_valid_o = 1, out_hart_o = 0, out_kind_o = 0, item 0xA; level returns to 0 after the handshake.
- NUM_HARTS = 2: push q0, q2, q4 in the same cycle; hold out_ready_i = 1 -> items emerge in order q0, q2, q4 on consecutive cycles; RR pointer ends at 5.
- out_ready_i = 0 for 5 cycles with q1 granted while q0 is also filled -> outputs stay fixed on q1; after ready, q1 pops first, then q0 (order by RR wrap).
- Fill q3 with DEPTH = 8 items, then a 9th push without pop -> push_ready_o[3] = 0, overflow_o[3] = 1, level = 8. A 9th push concurrent with a pop -> accepted, no overflow.
- Hart1 queues hold 3 items, grant locked on q4, assert flush_i[1] -> next cycle levels of q3..q5 = 0, overflow clear, out_valid_o = 0 if no other queue is non-empty.
- With COSIM_LOG_TIMESTAMP_EN: push at cycle 10 after reset, pop at cycle 20 -> out_time_o = 10.
